// File: rtl/qam_spi_pkg.sv
// rtl/qam_spi_pkg.sv - shared SPI frame constants and types for the qam_top configuration port
package qam_spi_pkg;

  localparam logic SPI_WRITE = 1'b1;
  localparam logic SPI_READ  = 1'b0;

  localparam int SPI_ADDR_W     = 10;
  localparam int SPI_DATA_W     = 8;
  localparam int SPI_FRAME_BITS = 33;
  localparam int SPI_DATA_FIRST = 20;
  localparam int SPI_DATA_LAST  = 27;
  localparam int SPI_BIT_CNT_W  = 6;

  localparam logic [SPI_ADDR_W-1:0] SPI_BASE_ICOEFF = 10'd128;
  localparam logic [SPI_ADDR_W-1:0] SPI_BASE_QCOEFF = 10'd256;
  localparam logic [SPI_ADDR_W-1:0] SPI_BASE_IOUT   = 10'd512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } spi_state_e;

  // Frame layout: rw, addr, 9 dead bits, data, 5 dead bits; read frames carry zero data.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic                  rw,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {rw, addr, 9'b0, (rw ? wdata : {SPI_DATA_W{1'b0}}), 5'b0};
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - CLK_DIV counter with synchronous clear, one-cycle tick per SCLK half-period
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/qam_spi_master.sv
// rtl/qam_spi_master.sv - SPI initiator turning one rw/addr/wdata request into a 33-SCLK frame
module qam_spi_master
  import qam_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic                  dsp_clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  CSN,
  input  logic                  MISO,
  input  logic                  MISO_enable
);

  localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALVES - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST  = SPI_BIT_CNT_W'(SPI_FRAME_BITS - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_DFIRST = SPI_BIT_CNT_W'(SPI_DATA_FIRST);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_DLAST  = SPI_BIT_CNT_W'(SPI_DATA_LAST);

  spi_state_e                  state, state_n;
  logic [SPI_FRAME_BITS-1:0]   tx_sr, tx_sr_n;
  logic [SPI_DATA_W-1:0]       rx_sr, rx_sr_n;
  logic [SPI_BIT_CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]               gap_cnt, gap_cnt_n;
  logic                        err, err_n;
  logic                        ready_n, rsp_valid_n, rsp_err_n;
  logic [SPI_DATA_W-1:0]       rsp_rdata_n;
  logic                        sclk_n, mosi_n, csn_n;
  logic                        tick;
  logic                        in_data;

  // Divider runs through SHIFT and GAP; held cleared in IDLE so a frame starts on a fresh phase.
  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk   (dsp_clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );

  assign in_data = (bit_cnt >= BIT_DFIRST) && (bit_cnt <= BIT_DLAST);

  always_comb begin
    state_n     = state;
    tx_sr_n     = tx_sr;
    rx_sr_n     = rx_sr;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    err_n       = err;
    ready_n     = req_ready;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    sclk_n      = SCLK;
    mosi_n      = MOSI;
    csn_n       = CSN;

    case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (req_valid && req_ready) begin
          tx_sr_n   = spi_frame(req_rw, req_addr, req_wdata);
          rx_sr_n   = '0;
          bit_cnt_n = '0;
          err_n     = 1'b0;
          ready_n   = 1'b0;
          csn_n     = 1'b0;
          sclk_n    = 1'b0;
          mosi_n    = req_rw;
          state_n   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!SCLK) begin
            sclk_n = 1'b1;
            if (in_data) begin
              rx_sr_n = {rx_sr[SPI_DATA_W-2:0], MISO_enable & MISO};
              err_n   = err | ~MISO_enable;
            end
          end else if (bit_cnt != BIT_LAST) begin
            sclk_n    = 1'b0;
            bit_cnt_n = bit_cnt + 1'b1;
            tx_sr_n   = {tx_sr[SPI_FRAME_BITS-2:0], 1'b0};
            mosi_n    = tx_sr[SPI_FRAME_BITS-2];
          end else begin
            // Last falling edge closes the frame and reports in the same cycle.
            sclk_n      = 1'b0;
            csn_n       = 1'b1;
            mosi_n      = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = rx_sr;
            rsp_err_n   = err;
            gap_cnt_n   = '0;
            state_n     = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            ready_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            gap_cnt_n = gap_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dsp_clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      CSN       <= 1'b1;
    end else begin
      state     <= state_n;
      tx_sr     <= tx_sr_n;
      rx_sr     <= rx_sr_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      err       <= err_n;
      req_ready <= ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      SCLK      <= sclk_n;
      MOSI      <= mosi_n;
      CSN       <= csn_n;
    end
  end

endmodule
